// File: rtl/cpu_run_ctrl_pkg.sv
// ============================================================================
//  Module      : cpu_run_ctrl_pkg
//  Description : Shared codes for the CPU run controller: command opcodes,
//                halt-cause codes and the run-control FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_run_ctrl_pkg;

    // Command opcodes carried on cmd_op (6 and 7 are ignored)
    localparam logic [2:0] OP_HALT    = 3'd0;
    localparam logic [2:0] OP_RUN     = 3'd1;
    localparam logic [2:0] OP_STEP    = 3'd2;
    localparam logic [2:0] OP_SET_BP0 = 3'd3;
    localparam logic [2:0] OP_SET_BP1 = 3'd4;
    localparam logic [2:0] OP_CLR_BP  = 3'd5;

    // Reason the controller last entered HALT
    localparam logic [2:0] CAUSE_RESET = 3'd0;
    localparam logic [2:0] CAUSE_CMD   = 3'd1;
    localparam logic [2:0] CAUSE_BP    = 3'd2;
    localparam logic [2:0] CAUSE_STEP  = 3'd3;
    localparam logic [2:0] CAUSE_WDOG  = 3'd4;

    // Run-control FSM states
    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/cpu_run_ctrl_bp_cmp.sv
// ============================================================================
//  Module      : cpu_bp_cmp
//  Description : One breakpoint register with enable and a word-granular
//                address compare (pc[1:0] is don't-care).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_bp_cmp
    import cpu_run_ctrl_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set_en,
    input  logic            clr_en,
    input  logic [PC_W-1:0] set_addr,
    input  logic [PC_W-1:0] pc,
    output logic            match
);

    logic [PC_W-3:0] addr_q;
    logic [PC_W-3:0] addr_d;
    logic            en_q;
    logic            en_d;
    logic            unused_lsb;

    // Byte-offset bits never take part in the compare
    assign unused_lsb = ^{set_addr[1:0], pc[1:0]};

    // Load on SET, drop the enable on CLR, otherwise hold
    always_comb begin
        addr_d = addr_q;
        en_d   = en_q;
        if (set_en) begin
            addr_d = set_addr[PC_W-1:2];
            en_d   = 1'b1;
        end else if (clr_en) begin
            en_d   = 1'b0;
        end
    end

    // Breakpoint register, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            en_q   <= 1'b0;
        end else begin
            addr_q <= addr_d;
            en_q   <= en_d;
        end
    end

    assign match = en_q && (pc[PC_W-1:2] == addr_q);

endmodule

`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
// ============================================================================
//  Module      : cpu_run_ctrl
//  Description : Debug run controller for a CPU: HALT/RUN/STEP FSM, two
//                word-address breakpoints with skip-once on resume, and a
//                saturating retired-instruction counter.
//                Optional watchdog enabled by macro CPU_RUN_CTRL_WDOG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int PC_W       = 32,
    parameter int CNT_W      = 32,
    parameter int AUTO_RUN   = 1,
    parameter int WDOG_LIMIT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [2:0]       cmd_op,
    input  logic [PC_W-1:0]  cmd_data,
    output logic             cmd_ready,
    input  logic [PC_W-1:0]  pc,
    output logic             cpu_en,
    output logic             halted,
    output logic [2:0]       halt_cause,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t           state_q, state_d;
    logic [2:0]       cause_q, cause_d;
    logic             skip_q, skip_d;   // first RUN cycle after HALT ignores breakpoints
    logic             auto_q, auto_d;   // pending auto-start after reset
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             cmd_halt, cmd_run, cmd_step, cmd_clr;
    logic [1:0]       bp_set;
    logic [1:0]       bp_match;
    logic             bp_hit;
    logic             wd_hit;

    assign cmd_halt  = cmd_valid && (cmd_op == OP_HALT);
    assign cmd_run   = cmd_valid && (cmd_op == OP_RUN);
    assign cmd_step  = cmd_valid && (cmd_op == OP_STEP);
    assign cmd_clr   = cmd_valid && (cmd_op == OP_CLR_BP);
    assign bp_set[0] = cmd_valid && (cmd_op == OP_SET_BP0);
    assign bp_set[1] = cmd_valid && (cmd_op == OP_SET_BP1);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bp
            cpu_bp_cmp #(
                .PC_W (PC_W)
            ) u_bp (
                .clk      (clk),
                .rst_n    (rst_n),
                .set_en   (bp_set[gi]),
                .clr_en   (cmd_clr),
                .set_addr (cmd_data),
                .pc       (pc),
                .match    (bp_match[gi])
            );
        end
    endgenerate

    assign bp_hit = (|bp_match) && !skip_q;

    // Retire enable: only in RUN (unless halted by command or breakpoint) or STEP
    always_comb begin
        cpu_en = 1'b0;
        case (state_q)
            ST_RUN:  cpu_en = !(cmd_halt || bp_hit);
            ST_STEP: cpu_en = 1'b1;
            default: cpu_en = 1'b0;
        endcase
    end

`ifdef CPU_RUN_CTRL_WDOG_EN
    localparam int WD_W = $clog2(WDOG_LIMIT + 1);

    logic [WD_W-1:0] wd_q, wd_d;

    assign wd_hit = (state_q == ST_RUN) && cpu_en &&
                    ((32'(wd_q) + 32'd1) >= 32'(WDOG_LIMIT));

    // Watchdog count: cleared on entry to RUN, bumped per retired RUN instruction
    always_comb begin
        wd_d = wd_q;
        if ((state_q != ST_RUN) && (state_d == ST_RUN)) begin
            wd_d = '0;
        end else if ((state_q == ST_RUN) && cpu_en) begin
            wd_d = wd_q + 1'b1;
        end
    end

    // Watchdog count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    logic unused_wdog;

    assign wd_hit      = 1'b0;
    assign unused_wdog = (WDOG_LIMIT != 0);
`endif

    // Next state and halt cause; halt priority is command > breakpoint > watchdog
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        skip_d  = skip_q;
        auto_d  = 1'b0;
        case (state_q)
            ST_HALT: begin
                if (auto_q || cmd_run) begin
                    state_d = ST_RUN;
                    skip_d  = 1'b1;
                end else if (cmd_step) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                state_d = ST_HALT;
                cause_d = CAUSE_STEP;
            end
            ST_RUN: begin
                skip_d = 1'b0;
                if (cmd_halt) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_CMD;
                end else if (bp_hit) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_BP;
                end else if (wd_hit) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_WDOG;
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    // Saturating retired-instruction count
    always_comb begin
        cnt_d = cnt_q;
        if (cpu_en && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Control registers, all forced to their halted values by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HALT;
            cause_q <= CAUSE_RESET;
            skip_q  <= 1'b0;
            auto_q  <= (AUTO_RUN != 0);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            skip_q  <= skip_d;
            auto_q  <= auto_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cmd_ready  = 1'b1;
    assign halted     = (state_q == ST_HALT);
    assign halt_cause = cause_q;
    assign instr_cnt  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
// ============================================================================
//  Module      : tb_cpu_run_ctrl
//  Description : Self-checking bench for cpu_run_ctrl: directed scenarios plus
//                randomized commands against a behavioural run-control model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_run_ctrl;

    localparam int WDL = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_op = 3'd0;
    logic [31:0] cmd_data = 32'd0;
    logic [31:0] pc = 32'd0;
    logic        cmd_ready;
    logic        cpu_en;
    logic        halted;
    logic [2:0]  halt_cause;
    logic [31:0] instr_cnt;

    cpu_run_ctrl #(
        .PC_W       (32),
        .CNT_W      (32),
        .AUTO_RUN   (1),
        .WDOG_LIMIT (WDL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_ready  (cmd_ready),
        .pc         (pc),
        .cpu_en     (cpu_en),
        .halted     (halted),
        .halt_cause (halt_cause),
        .instr_cnt  (instr_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int en_seen = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: what the debugger should observe
    bit          m_halted, m_step, m_fresh, m_auto, m_en;
    int          m_cause;
    logic [31:0] m_bp [2];
    bit          m_bpe [2];
    longint      m_cnt;
    int          m_wd;

    function automatic bit m_hit();
        bit h = 0;
        for (int i = 0; i < 2; i++)
            if (m_bpe[i] && ((pc >> 2) == (m_bp[i] >> 2))) h = 1;
        return h;
    endfunction

    task automatic m_reset();
        m_halted = 1; m_step = 0; m_fresh = 0; m_auto = 1; m_en = 0;
        m_cause = 0; m_cnt = 0; m_wd = 0;
        for (int i = 0; i < 2; i++) begin m_bp[i] = 0; m_bpe[i] = 0; end
    endtask

    task automatic m_advance(input bit v, input int op, input logic [31:0] d);
        bit hit, wd_trip;
        hit = m_hit();
        wd_trip = 0;
        if (m_en && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (m_halted) begin
            if (m_auto || (v && op == 1)) begin
                m_halted = 0; m_fresh = 1; m_wd = 0;
            end else if (v && op == 2) begin
                m_halted = 0; m_step = 1;
            end
        end else if (m_step) begin
            m_step = 0; m_halted = 1; m_cause = 3;
        end else begin
`ifdef CPU_RUN_CTRL_WDOG_EN
            if (m_en && (m_wd + 1 >= WDL)) wd_trip = 1;
`endif
            if (v && op == 0)          begin m_halted = 1; m_cause = 1; end
            else if (!m_fresh && hit)  begin m_halted = 1; m_cause = 2; end
            else if (wd_trip)          begin m_halted = 1; m_cause = 4; end
            if (m_en) m_wd++;
            m_fresh = 0;
        end
        m_auto = 0;
        if (v && op == 3) begin m_bp[0] = d; m_bpe[0] = 1; end
        if (v && op == 4) begin m_bp[1] = d; m_bpe[1] = 1; end
        if (v && op == 5) begin m_bpe[0] = 0; m_bpe[1] = 0; end
    endtask

    // One clock cycle: drive, check, clock, model update, CPU pc advance
    task automatic tick(input bit v, input int op, input logic [31:0] d);
        cmd_valid = v; cmd_op = op[2:0]; cmd_data = d;
        #1;
        m_en = 0;
        if (!m_halted) begin
            if (m_step) m_en = 1;
            else m_en = !(v && op == 0) && !(!m_fresh && m_hit());
        end
        check("cpu_en", cpu_en, m_en);
        check("halted", halted, m_halted);
        check("halt_cause", halt_cause, m_cause);
        check("instr_cnt", instr_cnt, m_cnt);
        check("cmd_ready", cmd_ready, 1);
        if (cpu_en) en_seen++;
        @(posedge clk);
        m_advance(v, op, d);
        #1;
        if (m_en) pc = pc + 32'd4;
        @(negedge clk);
    endtask

    // Asynchronous reset pulse between clock edges
    task automatic do_reset();
        cmd_valid = 0;
        rst_n = 0;
        #1;
        check("rst_cpu_en", cpu_en, 0);
        check("rst_halted", halted, 1);
        check("rst_cause", halt_cause, 0);
        check("rst_cnt", instr_cnt, 0);
        m_reset();
        pc = 0;
        #1 rst_n = 1;
    endtask

    task automatic wait_halt(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (halted) break;
            tick(0, 0, 0);
        end
        check("wait_halt", halted, 1);
    endtask

    initial begin
        int p0;
        @(negedge clk);

        // Auto-run out of reset, 8 retired instructions
        do_reset();
        for (int i = 0; i < 9; i++) tick(0, 0, 0);
        check("auto_running", halted, 0);
        check("auto_cnt8", instr_cnt, 8);

        // Two breakpoints, stop at the lower one then resume to the other
        do_reset();
        tick(1, 3, 32'h98);
        tick(1, 4, 32'h90);
        wait_halt(100);
`ifndef CPU_RUN_CTRL_WDOG_EN
        check("bp1_pc", pc, 32'h90);
        check("bp1_cause", halt_cause, 2);
        check("bp1_cnt", instr_cnt, 36);
        tick(1, 1, 0);
        wait_halt(100);
        check("bp0_pc", pc, 32'h98);
        check("bp0_cause", halt_cause, 2);
        check("bp0_cnt", instr_cnt, 38);
`else
        check("wd_cause", halt_cause, 4);
        check("wd_cnt", instr_cnt, WDL);
`endif

        // STEP from a breakpoint at 0x10: one pulse then HALT/STEP
        do_reset();
        tick(1, 3, 32'h10);
        wait_halt(50);
        check("step_start_pc", pc, 32'h10);
        p0 = en_seen;
        tick(1, 2, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0);
        check("step_pulses", en_seen - p0, 1);
        check("step_halted", halted, 1);
        check("step_cause", halt_cause, 3);
        check("step_pc", pc, 32'h14);

        // HALT command coinciding with a breakpoint match
        tick(1, 4, 32'h20);
        tick(1, 1, 0);
        for (int i = 0; i < 20; i++) begin
            if (pc == 32'h20) begin tick(1, 0, 0); break; end
            tick(0, 0, 0);
        end
        check("prio_pc", pc, 32'h20);
        check("prio_cause", halt_cause, 1);

        // Reset asserted while running
        tick(1, 5, 0);
        tick(1, 1, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0);
        check("pre_rst_running", halted, 0);
        do_reset();

        // Watchdog behaviour with no breakpoints
`ifdef CPU_RUN_CTRL_WDOG_EN
        wait_halt(60);
        check("wdog_cause", halt_cause, 4);
        check("wdog_cnt", instr_cnt, WDL);
`else
        for (int i = 0; i < 40; i++) tick(0, 0, 0);
        check("no_wdog", halted, 0);
`endif

        // Randomized commands against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit          v;
            int          op;
            logic [31:0] d;
            if ($urandom_range(0, 499) == 0) do_reset();
            v  = ($urandom_range(0, 5) == 0);
            op = int'($urandom_range(0, 7));
            d  = pc + 32'(4 * $urandom_range(0, 24)) + 32'($urandom_range(0, 3));
            tick(v, op, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameter PC_W, default 32: width of the CPU program counter.
REQ-002 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-003 Parameter AUTO_RUN, default 1: when 1, the block leaves HALT for RUN on the first clock edge after reset.
REQ-004 Parameter WDOG_LIMIT, default 1024: number of consecutive retired instructions in RUN before a watchdog halt.
REQ-005 clk  input  1  single system clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 cmd_valid  input  1  command strobe, sampled at the rising edge.
REQ-008 cmd_op  input  3  0 HALT, 1 RUN, 2 STEP, 3 SET_BP0, 4 SET_BP1, 5 CLR_BP; 6 and 7 are ignored.
REQ-009 cmd_data  input  PC_W  breakpoint address for SET_BP0 and SET_BP1.
REQ-010 cmd_ready  output  1  constant 1 out of reset; every valid command is accepted in its cycle.
REQ-011 pc  input  PC_W  address of the CPU's current instruction.
REQ-012 cpu_en  output  1  when 1, the CPU retires the instruction at pc on this edge (combinational from state, pc and breakpoints).
REQ-013 halted  output  1  registered; 1 in HALT state.
REQ-014 halt_cause  output  3  registered: 0 RESET, 1 CMD, 2 BP, 3 STEP, 4 WDOG.
REQ-015 instr_cnt  output  CNT_W  count of cycles in which cpu_en was 1.

Function
REQ-016 The FSM SHALL have exactly three states: HALT, RUN and STEP.
REQ-017 In HALT, cpu_en SHALL be 0.
REQ-018 In HALT, RUN SHALL go to RUN, STEP SHALL go to STEP, and HALT SHALL leave halt_cause unchanged.
REQ-019 In STEP, cpu_en SHALL be 1 for exactly one cycle, then go to HALT with cause STEP; breakpoints are ignored in STEP.
REQ-020 In RUN, cpu_en SHALL be 1 unless pc[PC_W-1:2] equals an enabled breakpoint's address[PC_W-1:2]; pc[1:0] is ignored in the compare.
REQ-021 On a breakpoint match in RUN, cpu_en SHALL be 0 in the same cycle, so the instruction at the breakpoint is not retired, and the next state SHALL be HALT with cause BP.
REQ-022 The first RUN cycle after leaving HALT SHALL suppress breakpoint matching (skip-once), so resuming from a breakpoint retires that instruction.
REQ-023 A HALT command in RUN SHALL force cpu_en to 0 in that cycle and go to HALT with cause CMD.
REQ-024 RUN and STEP commands received outside HALT SHALL be ignored.
REQ-025 SET_BPn SHALL load cmd_data into breakpoint n and set its enable; CLR_BP SHALL clear both enables; these commands are accepted in any state and take effect from the next cycle.
REQ-026 Halt priority within one cycle SHALL be HALT command > breakpoint > watchdog.
REQ-027 instr_cnt SHALL increment by 1 on each edge where cpu_en is 1 and SHALL saturate at all-ones.

Reset
REQ-028 While rst_n is 0, the block SHALL immediately force state HALT, cpu_en 0, halted 1, halt_cause RESET, both breakpoint enables 0, breakpoint addresses 0, instr_cnt 0 and the watchdog count 0.
REQ-029 Reset asserted mid-RUN SHALL drop cpu_en in the same cycle, without waiting for a clock edge.

Configuration
REQ-030 With CPU_RUN_CTRL_WDOG_EN defined, a watchdog count SHALL clear on entry to RUN and increment on each retired instruction in RUN; on reaching WDOG_LIMIT, the block SHALL go to HALT with cause WDOG.
REQ-031 Without CPU_RUN_CTRL_WDOG_EN, no watchdog logic SHALL exist, cause WDOG SHALL never be produced, and WDOG_LIMIT SHALL be unused.

Structure
REQ-032 Package cpu_run_ctrl_pkg SHALL hold the cmd_op codes, the halt_cause codes and the FSM state enum.
REQ-033 Sub-module cpu_bp_cmp SHALL hold one breakpoint register, its enable, and the masked address compare; it SHALL be instantiated twice.

Verification
REQ-034 Reset release with AUTO_RUN=1 and pc stepping by 4 from 0x0 -> halted falls on the first edge; instr_cnt=8 after 8 cycles.
REQ-035 SET_BP0 0x98, SET_BP1 0x90, then run from 0x0 -> halt at pc=0x90 with cause 2, cpu_en 0 at 0x90, instr_cnt=36.
REQ-036 Halted at the 0x90 breakpoint, issue RUN -> 0x90 is retired, then halt at 0x98 with cause 2.
REQ-037 STEP while halted at pc=0x10 -> exactly one cpu_en pulse, then halted=1 with cause 3.
REQ-038 HALT command and breakpoint match in the same cycle -> cause 1; rst_n low mid-RUN -> cpu_en 0 before the next edge and cause 0.
REQ-039 With CPU_RUN_CTRL_WDOG_EN defined, WDOG_LIMIT=16 and no breakpoints -> halt after 16 retired instructions with cause 4; without the macro, the same stimulus never halts.
